// File: rtl/operation_r_seq_bw16.sv
// operation_r_seq_bw16: primitive-recursion sequencer driving external base/step units.
// Optional sub-unit watchdog enabled by defining OP_TIMEOUT_EN.
module operation_r_seq_bw16 #(
    parameter int BW  = 16,
    parameter int TMO = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    output logic          RD,
    output logic [BW-1:0] RES,
    input  logic [BW-1:0] IN0,
    input  logic [BW-1:0] IN1,
    output logic          B_ST,
    input  logic          B_RD,
    input  logic [BW-1:0] B_RES,
    output logic          S_ST,
    input  logic          S_RD,
    input  logic [BW-1:0] S_RES,
    output logic [BW-1:0] S_ACC,
    output logic [BW-1:0] S_X,
    output logic [BW-1:0] S_CNT,
    output logic          ERR
);
    typedef enum logic [2:0] {IDLE, B_GO, B_LO, B_HI, S_GO, S_LO, S_HI, DONE} state_t;
    state_t        r_state, w_next;
    logic          r_st, r_arm;
    logic [BW-1:0] r_x, r_n, r_i, r_acc;
    logic          w_start, w_last, w_wait;
    // r_arm blocks a start until ST has been seen low after reset
    assign w_start = ST & ~r_st & r_arm & (r_state == IDLE || r_state == DONE);
    assign w_last  = (r_i + BW'(1)) == r_n;
    assign w_wait  = r_state == B_LO || r_state == B_HI || r_state == S_LO || r_state == S_HI;
    assign RD      = r_state == IDLE || r_state == DONE;
    assign B_ST    = r_state == B_GO;
    assign S_ST    = r_state == S_GO;
    assign RES     = r_acc;
    assign S_ACC   = r_acc;
    assign S_X     = r_x;
    assign S_CNT   = r_i;
`ifdef OP_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err, w_to;
    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_start ? B_GO : r_state;
            B_GO:       w_next = B_LO;
            B_LO:       w_next = B_RD ? B_LO : B_HI;
            B_HI:       w_next = !B_RD ? B_HI : (r_n == '0 ? DONE : S_GO);
            S_GO:       w_next = S_LO;
            S_LO:       w_next = S_RD ? S_LO : S_HI;
            S_HI:       w_next = !S_RD ? S_HI : (w_last ? DONE : S_GO);
            default:    w_next = IDLE;
        endcase
`ifdef OP_TIMEOUT_EN
        w_to = w_wait && w_next == r_state && r_cnt == CW'(TMO - 1);
        if (w_to) w_next = DONE;
`endif
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_st    <= 1'b0;
            r_arm   <= 1'b0;
            r_x     <= '0;
            r_n     <= '0;
            r_i     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next;
            r_st    <= ST;
            r_arm   <= r_arm | ~ST;
            if (w_start) begin
                r_x <= IN0;
                r_n <= IN1;
                r_i <= '0;
            end
            if (r_state == B_HI && B_RD) r_acc <= B_RES;
            if (r_state == S_HI && S_RD) begin
                r_acc <= S_RES;
                r_i   <= r_i + BW'(1);
            end
        end
    end
`ifdef OP_TIMEOUT_EN
    // counter restarts whenever the state changes and only runs while waiting on a sub-unit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state || !w_wait) ? '0 : r_cnt + CW'(1);
            r_err <= w_to ? 1'b1 : (w_start ? 1'b0 : r_err);
        end
    end
`endif
endmodule

// File: tb/tb_operation_r_seq_bw16.sv
// tb_operation_r_seq_bw16: directed table-driven bench with base/step unit responders.
module tb_operation_r_seq_bw16;
    localparam int BW = 16;
    logic          CLK = 1'b0, RST = 1'b0, ST = 1'b0;
    logic          RD, B_ST, S_ST, ERR;
    logic          B_RD = 1'b1, S_RD = 1'b1;
    logic [BW-1:0] RES, S_ACC, S_X, S_CNT;
    logic [BW-1:0] IN0 = '0, IN1 = '0, B_RES = '0, S_RES = '0;
    int n_run = 0, n_fail = 0;
    int b_total = 0, s_total = 0, b_cnt = 0, s_cnt = 0, hang_at = 1 << 30;
    logic [BW-1:0] s_log [0:1023];

    always #5 CLK = ~CLK;

    operation_r_seq_bw16 #(.BW(BW), .TMO(8)) dut (
        .CLK(CLK), .RST(RST), .ST(ST), .RD(RD), .RES(RES), .IN0(IN0), .IN1(IN1),
        .B_ST(B_ST), .B_RD(B_RD), .B_RES(B_RES), .S_ST(S_ST), .S_RD(S_RD),
        .S_RES(S_RES), .S_ACC(S_ACC), .S_X(S_X), .S_CNT(S_CNT), .ERR(ERR)
    );

    // base returns 0, step returns acc+x; each holds RD low for 2 cycles
    always @(posedge CLK) begin
        if (B_ST) begin
            b_total++;
            B_RD  <= 1'b0;
            B_RES <= '0;
            b_cnt = 2;
        end else if (b_cnt > 0) begin
            if (b_cnt == 1) B_RD <= 1'b1;
            b_cnt--;
        end
        if (S_ST) begin
            s_log[s_total % 1024] = S_CNT;
            S_RD  <= 1'b0;
            S_RES <= S_ACC + S_X;
            s_cnt = (s_total >= hang_at) ? 0 : 2;
            s_total++;
        end else if (s_cnt > 0) begin
            if (s_cnt == 1) S_RD <= 1'b1;
            s_cnt--;
        end
    end

    typedef struct {
        logic [BW-1:0] x;
        logic [BW-1:0] n;
        logic [BW-1:0] res;
    } vec_t;
    vec_t vt [7];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic start_op(input logic [BW-1:0] x, input logic [BW-1:0] n);
        @(negedge CLK);
        IN0 = x;
        IN1 = n;
        ST  = 1'b1;
        @(negedge CLK);
        ST  = 1'b0;
        IN0 = ~x;
        IN1 = n + 16'd3;
        check("start latency B_ST", {31'd0, B_ST}, 32'd1);
        check("busy after start", {31'd0, RD}, 32'd0);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (RD !== 1'b1 && cyc < 5000) begin
            @(negedge CLK);
            cyc++;
        end
        check("done in time", {31'd0, cyc < 5000}, 32'd1);
    endtask

    task automatic wait_steps(input int target);
        int cyc = 0;
        while (s_total < target && cyc < 500) begin
            @(negedge CLK);
            cyc++;
        end
        check("step reached", {31'd0, s_total >= target}, 32'd1);
    endtask

    initial begin
        int b0, s0, dt;
        #1000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, s0, cyc;
        vt[0] = '{16'd3, 16'd4, 16'd12};
        vt[1] = '{16'd7, 16'd0, 16'd0};
        vt[2] = '{16'd0, 16'd2, 16'd0};
        vt[3] = '{16'd100, 16'd1, 16'd100};
        vt[4] = '{16'hFFFF, 16'd2, 16'hFFFE};
        vt[5] = '{16'd9, 16'd7, 16'd63};
        vt[6] = '{16'd1, 16'd300, 16'd300};
        #1;
        check("reset RD", {31'd0, RD}, 32'd1);
        check("reset RES", {16'd0, RES}, 32'd0);
        check("reset B_ST", {31'd0, B_ST}, 32'd0);
        check("reset S_ST", {31'd0, S_ST}, 32'd0);
        check("reset ERR", {31'd0, ERR}, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int v = 0; v < 7; v++) begin
            b0 = b_total;
            s0 = s_total;
            start_op(vt[v].x, vt[v].n);
            wait_done();
            check($sformatf("vec%0d RES", v), {16'd0, RES}, {16'd0, vt[v].res});
            check($sformatf("vec%0d ERR", v), {31'd0, ERR}, 32'd0);
            check($sformatf("vec%0d B_ST pulses", v), b_total - b0, 32'd1);
            check($sformatf("vec%0d S_ST pulses", v), s_total - s0, {16'd0, vt[v].n});
            if (v == 0)
                for (int k = 0; k < 4; k++)
                    check($sformatf("S_CNT step %0d", k), {16'd0, s_log[(s0 + k) % 1024]}, k);
            repeat (2) @(negedge CLK);
            check($sformatf("vec%0d RES hold", v), {16'd0, RES}, {16'd0, vt[v].res});
        end

        // second start edge during the step phase is ignored
        b0 = b_total;
        s0 = s_total;
        start_op(16'd5, 16'd3);
        wait_steps(s0 + 1);
        @(negedge CLK);
        ST = 1'b1;
        @(negedge CLK);
        ST = 1'b0;
        wait_done();
        check("ignored start RES", {16'd0, RES}, 32'd15);
        check("ignored start B pulses", b_total - b0, 32'd1);
        check("ignored start S pulses", s_total - s0, 32'd3);

        // reset during the second step aborts immediately
        s0 = s_total;
        start_op(16'd2, 16'd5);
        wait_steps(s0 + 2);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort RD", {31'd0, RD}, 32'd1);
        check("abort RES", {16'd0, RES}, 32'd0);
        check("abort B_ST", {31'd0, B_ST}, 32'd0);
        check("abort S_ST", {31'd0, S_ST}, 32'd0);
        b0 = b_total;
        s0 = s_total;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort no B pulses", b_total - b0, 32'd0);
        check("abort no S pulses", s_total - s0, 32'd0);
        start_op(16'd2, 16'd5);
        wait_done();
        check("fresh after abort RES", {16'd0, RES}, 32'd10);
        check("fresh after abort S pulses", s_total - s0, 32'd5);

        // ST held high across reset release must not start
        @(negedge CLK);
        ST  = 1'b1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        b0 = b_total;
        repeat (5) @(negedge CLK);
        check("held ST no start RD", {31'd0, RD}, 32'd1);
        check("held ST no B pulse", b_total - b0, 32'd0);
        ST = 1'b0;
        start_op(16'd6, 16'd2);
        wait_done();
        check("after held ST RES", {16'd0, RES}, 32'd12);

`ifdef OP_TIMEOUT_EN
        // second step never completes: watchdog must end the operation
        s0 = s_total;
        hang_at = s0 + 1;
        start_op(16'd1, 16'd3);
        wait_steps(s0 + 2);
        cyc = 0;
        while (RD !== 1'b1 && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        check("timeout within 9", {31'd0, cyc <= 9}, 32'd1);
        check("timeout RD", {31'd0, RD}, 32'd1);
        check("timeout ERR", {31'd0, ERR}, 32'd1);
        check("timeout RES", {16'd0, RES}, 32'd1);
        hang_at = 1 << 30;
        start_op(16'd4, 16'd2);
        wait_done();
        check("ERR cleared by start", {31'd0, ERR}, 32'd0);
        check("after timeout RES", {16'd0, RES}, 32'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
